// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared state encoding and line-level constants        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_LINE_IDLE = 1'b1;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_baud_tick : bit-period divider, flags last cycle of a bit   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int                DIV_W      = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0]  LAST_COUNT = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] count;

    // Restarting on bit_end keeps every bit exactly CLKS_PER_BIT cycles long.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear || bit_end)
            count <= '0;
        else
            count <= count + DIV_W'(1);
    end

    assign bit_end = (count == LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_frame : parametrised UART transmitter, start/data/stop.  |
// | Optional parity bit when UART_TX_PARITY_EN is defined. Rev 1.0   |
// +------------------------------------------------------------------+
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int                   BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    tx_state_t              state, state_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_next;
    logic                   stop_cnt, stop_cnt_next;
    logic                   line_next;
    logic                   done_next;
    logic                   bit_end;

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clock   (clock),
        .reset   (reset),
        .clear   (tx_ready),
        .bit_end (bit_end)
    );

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_SENSE = 1'(PARITY_ODD);
    logic parity_bit;

    // Parity is taken from the word at capture, before it is shifted out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            parity_bit <= 1'b0;
        else if (tx_ready && tx_valid)
            parity_bit <= (^tx_data) ^ PARITY_SENSE;
    end
`endif

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        line_next     = serial_out;
        done_next     = 1'b0;
        unique case (state)
            IDLE: begin
                line_next     = UART_LINE_IDLE;
                bit_cnt_next  = '0;
                stop_cnt_next = 1'b0;
                if (tx_valid) begin
                    state_next = START;
                    shift_next = tx_data;
                    line_next  = UART_START_BIT;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    line_next    = shift_reg[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        line_next  = parity_bit;
`else
                        state_next = STOP;
                        line_next  = UART_STOP_BIT;
`endif
                    end else begin
                        shift_next   = shift_reg >> 1;
                        line_next    = shift_reg[1];
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    line_next  = UART_STOP_BIT;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_next = IDLE;
                        line_next  = UART_LINE_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = UART_LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            serial_out <= UART_LINE_IDLE;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            stop_cnt   <= stop_cnt_next;
            serial_out <= line_next;
            tx_done    <= done_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_frame : directed bench, per-cycle line scoreboard     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_tx_frame;

    localparam int DB_A = 8, CPB_A = 4, SB_A = 1;
    localparam int DB_B = 7, CPB_B = 3, SB_B = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a, line_a, busy_a, done_a;
    logic [6:0] data_b;
    logic       valid_b;
    logic       ready_b, line_b, busy_b, done_b;

    int   tests = 0;
    int   fails = 0;
    logic exp_q[$];

    always #5 clock = ~clock;

    uart_tx_frame #(
        .DATA_BITS(DB_A), .CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A), .PARITY_ODD(0)
    ) dut_a (
        .clock(clock), .reset(reset), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .serial_out(line_a), .busy(busy_a), .tx_done(done_a)
    );

    uart_tx_frame #(
        .DATA_BITS(DB_B), .CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B), .PARITY_ODD(0)
    ) dut_b (
        .clock(clock), .reset(reset), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .serial_out(line_b), .busy(busy_b), .tx_done(done_b)
    );

    function automatic logic get_line(input bit sel);  return sel ? line_b  : line_a;  endfunction
    function automatic logic get_ready(input bit sel); return sel ? ready_b : ready_a; endfunction
    function automatic logic get_busy(input bit sel);  return sel ? busy_b  : busy_a;  endfunction
    function automatic logic get_done(input bit sel);  return sel ? done_b  : done_a;  endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for every cycle of one frame, LSB first.
    task automatic push_frame(input logic [8:0] d, input int dbits, input int cpb, input int sb);
        logic p;
        p = 1'b0;
        repeat (cpb) exp_q.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            repeat (cpb) exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
`ifdef UART_TX_PARITY_EN
        repeat (cpb) exp_q.push_back(p);
`endif
        repeat (sb * cpb) exp_q.push_back(1'b1);
    endtask

    task automatic accept(input bit sel, input logic [8:0] d);
        @(negedge clock);
        check(sel ? "ready_before_b" : "ready_before_a", 32'(get_ready(sel)), 32'd1);
        if (sel) begin data_b = d[6:0]; valid_b = 1'b1; end
        else     begin data_a = d[7:0]; valid_a = 1'b1; end
        @(posedge clock);
        if (sel) push_frame(d, DB_B, CPB_B, SB_B);
        else     push_frame(d, DB_A, CPB_A, SB_A);
        #1;
        if (sel) valid_b = 1'b0; else valid_a = 1'b0;
    endtask

    task automatic drain(input bit sel, input bit disturb);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("line", 32'(get_line(sel)), 32'(exp_q.pop_front()));
            check("ready_mid", 32'(get_ready(sel)), 32'd0);
            check("busy_mid", 32'(get_busy(sel)), 32'd1);
            check("done_mid", 32'(get_done(sel)), 32'd0);
            if (disturb) begin
                valid_a = 1'($urandom_range(0, 1));
                data_a  = 8'($urandom);
            end
        end
        if (disturb) valid_a = 1'b0;
    endtask

    task automatic end_check(input bit sel);
        @(negedge clock);
        check("done_pulse", 32'(get_done(sel)), 32'd1);
        check("ready_end", 32'(get_ready(sel)), 32'd1);
        check("busy_end", 32'(get_busy(sel)), 32'd0);
        check("line_end", 32'(get_line(sel)), 32'd1);
    endtask

    task automatic after_check(input bit sel);
        @(negedge clock);
        check("done_low", 32'(get_done(sel)), 32'd0);
        check("line_idle", 32'(get_line(sel)), 32'd1);
    endtask

    initial begin
        data_a = '0; valid_a = 1'b0; data_b = '0; valid_b = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_line_a", 32'(line_a), 32'd1);
        check("rst_ready_a", 32'(ready_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_line_b", 32'(line_b), 32'd1);
        check("rst_ready_b", 32'(ready_b), 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_line_a", 32'(line_a), 32'd1);
        check("idle_busy_a", 32'(busy_a), 32'd0);

        // Single frame 0xA5, done exactly 40 cycles after accept
        accept(1'b0, 9'h0A5);
        drain(1'b0, 1'b0);
        end_check(1'b0);
        after_check(1'b0);

        // Back-to-back 0x00 then 0xFF with valid held high
        @(negedge clock);
        data_a = 8'h00; valid_a = 1'b1;
        @(posedge clock);
        push_frame(9'h000, DB_A, CPB_A, SB_A);
        #1 data_a = 8'hFF;
        drain(1'b0, 1'b0);
        end_check(1'b0);
        @(posedge clock);
        push_frame(9'h0FF, DB_A, CPB_A, SB_A);
        #1 valid_a = 1'b0;
        drain(1'b0, 1'b0);
        end_check(1'b0);
        after_check(1'b0);

        // Inputs wiggled while busy must not disturb the line
        accept(1'b0, 9'h03C);
        drain(1'b0, 1'b1);
        end_check(1'b0);
        after_check(1'b0);

        // Parity-sensitive words
        accept(1'b0, 9'h007);
        drain(1'b0, 1'b0);
        end_check(1'b0);
        after_check(1'b0);

        // Seven data bits, two stop bits, three clocks per bit
        accept(1'b1, 9'h07F);
        drain(1'b1, 1'b0);
        end_check(1'b1);
        after_check(1'b1);

        // Async reset in cycle 13 of a frame, then a clean frame
        accept(1'b0, 9'h05A);
        repeat (13) @(negedge clock);
        exp_q.delete();
        #1 reset = 1'b1;
        #1;
        check("abort_line", 32'(line_a), 32'd1);
        check("abort_ready", 32'(ready_a), 32'd1);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        accept(1'b0, 9'h0C3);
        drain(1'b0, 1'b0);
        end_check(1'b0);
        after_check(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
